// File: rtl/ghpc_share_decoder.sv
// rtl/ghpc_share_decoder.sv - share-pair capture, recombination and credit-protected output FIFO
//
// Receiving end of a masked two-share gadget pipeline of fixed latency LAT.
// Every accepted issue is tracked by a tag that walks a LAT-bit shift register.
// When the tag reaches the last stage, the arriving share pair is registered.
// The registered shares are XOR-recombined into the output FIFO on the next edge.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   issue    / issue_ok upstream launch request / credit available (accept = both high)
//   sh0, sh1            share pair from the gadget pipeline, valid only in tagged cycles
//   out_data, out_valid head of FIFO and FIFO non-empty
//   out_ready           consumer pops the head when high together with out_valid
//   drop_err            sticky flag: issue seen while issue_ok was low
module ghpc_share_decoder #(
    parameter int W     = 1,
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         issue,
    output logic         issue_ok,
    input  logic [W-1:0] sh0,
    input  logic [W-1:0] sh1,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         drop_err
);

    // Pointers need at least one bit even for a single-entry FIFO; they wrap
    // explicitly at DEPTH-1 so the extra bit is never used in that case.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_P  = AW'(DEPTH - 1);

    logic [LAT-1:0] tag_q, tag_d;
    logic           cap_v_q, cap_v_d;
    logic [W-1:0]   s0_q, s0_d;
    logic [W-1:0]   s1_q, s1_d;
    logic [CW-1:0]  occ_q, occ_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic           drop_q, drop_d;
    logic [W-1:0]   mem_q [DEPTH];

    logic acc;
    logic pop;
    logic wr_en;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_P) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        // Credit is decoded from registered occupancy only, so a pop never
        // frees credit in the same cycle.
        issue_ok  = (occ_q < DEPTH_C);
        out_valid = (cnt_q != '0);
        out_data  = mem_q[rd_q];
        drop_err  = drop_q;

        acc   = issue & issue_ok;
        pop   = out_valid & out_ready;
        wr_en = cap_v_q;

        tag_d   = (tag_q << 1) | LAT'(acc);
        cap_v_d = tag_q[LAT-1];

        // Shares are only sampled in tagged cycles and kept in separate
        // registers; they meet for the first time at the XOR on the FIFO input.
        s0_d = tag_q[LAT-1] ? sh0 : s0_q;
        s1_d = tag_q[LAT-1] ? sh1 : s1_q;

        // occ counts in-flight tags plus stored entries, so the FIFO can
        // never be written while full.
        occ_d = occ_q + CW'(acc) - CW'(pop);
        cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
        wr_d  = wr_en ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop   ? ptr_inc(rd_q) : rd_q;

        drop_d = drop_q | (issue & ~issue_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            cap_v_q <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            occ_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            drop_q  <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            cap_v_q <= cap_v_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_q] <= s0_q ^ s1_q;
        end
    end

endmodule

// File: tb/tb_ghpc_share_decoder.sv
// tb/tb_ghpc_share_decoder.sv - self-checking bench for ghpc_share_decoder
module tb_ghpc_share_decoder;

    localparam int W     = 8;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         issue = 1'b0;
    logic         issue_ok;
    logic [W-1:0] sh0 = '0;
    logic [W-1:0] sh1 = '0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         drop_err;

    ghpc_share_decoder #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .issue_ok  (issue_ok),
        .sh0       (sh0),
        .sh1       (sh1),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q [$];

    typedef struct packed {
        logic         iss;
        logic         rdy;
        logic [W-1:0] s0;
        logic [W-1:0] s1;
        logic         ok;
        logic         vld;
        logic [W-1:0] dat;
        logic         drp;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [W-1:0] pat0(input int e);
        return W'(e * 19 + 3);
    endfunction

    function automatic logic [W-1:0] pat1(input int e);
        return W'((e * 7) ^ 165);
    endfunction

    function automatic logic [W-1:0] pat_val(input int e);
        return pat0(e) ^ pat1(e);
    endfunction

    // Drive a distinct, valid-looking share pair every cycle, then clock.
    task automatic tick_auto();
        sh0 = pat0(cyc);
        sh1 = pat1(cyc);
        step();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        issue     = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_issue_ok", issue_ok, 1);
        chk("rst_drop_err", drop_err, 0);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic drain();
        int budget = 40;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            if (out_valid) begin
                chk("drain_data", out_data, exp_q.pop_front());
            end
            tick_auto();
            budget--;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d entries missing want 0", exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b0;
    endtask

    task automatic run_table();
        tbl[0]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        for (int i = 0; i < 17; i++) begin
            issue     = tbl[i].iss;
            out_ready = tbl[i].rdy;
            sh0       = tbl[i].s0;
            sh1       = tbl[i].s1;
            step();
            chk($sformatf("tbl%0d_issue_ok", i), issue_ok, tbl[i].ok);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].vld);
            if (tbl[i].vld) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].dat);
            chk($sformatf("tbl%0d_drop_err", i), drop_err, tbl[i].drp);
        end
        issue     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic run_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            issue = 1'b1;
            tick_auto();
            chk($sformatf("bp_issue_ok_%0d", k), issue_ok, (k < 3) ? 1 : 0);
            chk($sformatf("bp_drop_%0d", k), drop_err, (k == 4) ? 1 : 0);
        end
        issue = 1'b0;
        for (int k = 5; k < 10; k++) begin
            tick_auto();
            chk("bp_stall_issue_ok", issue_ok, 0);
            chk("bp_stall_valid", out_valid, 1);
            chk("bp_stall_head", out_data, pat_val(4));
        end
        out_ready = 1'b1;
        tick_auto();
        out_ready = 1'b0;
        chk("bp_credit_back", issue_ok, 1);
        chk("bp_after_pop_valid", out_valid, 1);
        chk("bp_after_pop_head", out_data, pat_val(5));
        exp_q = '{pat_val(5), pat_val(6), pat_val(7)};
        drain();
        repeat (3) tick_auto();
        chk("bp_fifth_untracked", out_valid, 0);
        chk("bp_drop_sticky", drop_err, 1);
        chk("bp_final_issue_ok", issue_ok, 1);
    endtask

    task automatic run_midflight_reset();
        issue = 1'b1;
        repeat (3) tick_auto();
        issue = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mf_issue_ok_release", issue_ok, 1);
        for (int k = 0; k < 10; k++) begin
            tick_auto();
            chk("mf_no_valid", out_valid, 0);
            chk("mf_issue_ok", issue_ok, 1);
            chk("mf_drop_clear", drop_err, 0);
        end
    endtask

    task automatic run_simultaneous();
        out_ready = 1'b0;
        issue     = 1'b1;
        repeat (2) tick_auto();
        issue = 1'b0;
        repeat (4) tick_auto();
        chk("sim_pre_valid", out_valid, 1);
        chk("sim_pre_head", out_data, pat_val(4));
        // occ = 2, one entry stored, second one written on this same edge
        issue     = 1'b1;
        out_ready = 1'b1;
        tick_auto();
        out_ready = 1'b0;
        chk("sim_issue_ok", issue_ok, 1);
        chk("sim_valid", out_valid, 1);
        chk("sim_head", out_data, pat_val(5));
        tick_auto();
        chk("sim_occ3_issue_ok", issue_ok, 1);
        tick_auto();
        chk("sim_occ4_issue_ok", issue_ok, 0);
        issue = 1'b0;
        exp_q = '{pat_val(5), pat_val(10), pat_val(11), pat_val(12)};
        drain();
        repeat (2) tick_auto();
        chk("sim_empty", out_valid, 0);
        chk("sim_credit", issue_ok, 1);
    endtask

    task automatic run_random(input int n);
        int           occ_m  = 0;
        bit           drop_m = 0;
        int           e      = 0;
        int           pend [$];
        int           wq_at [$];
        logic [W-1:0] wq_v [$];
        logic [W-1:0] fq [$];
        bit           ok_m, acc, pop;
        for (int i = 0; i < n; i++) begin
            issue     = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 5);
            sh0       = W'($urandom);
            sh1       = W'($urandom);
            ok_m = (occ_m < DEPTH);
            acc  = issue && ok_m;
            pop  = (fq.size() > 0) && out_ready;
            step();
            if (pop) void'(fq.pop_front());
            if (wq_at.size() > 0 && wq_at[0] == e) begin
                void'(wq_at.pop_front());
                fq.push_back(wq_v.pop_front());
            end
            if (pend.size() > 0 && pend[0] == e) begin
                void'(pend.pop_front());
                wq_v.push_back(sh0 ^ sh1);
                wq_at.push_back(e + 1);
            end
            if (acc) pend.push_back(e + LAT);
            occ_m = occ_m + int'(acc) - int'(pop);
            if (issue && !ok_m) drop_m = 1;
            e++;
            chk("rnd_issue_ok", issue_ok, (occ_m < DEPTH) ? 1 : 0);
            chk("rnd_out_valid", out_valid, (fq.size() > 0) ? 1 : 0);
            if (fq.size() > 0) chk("rnd_out_data", out_data, fq[0]);
            chk("rnd_drop_err", drop_err, drop_m);
        end
        issue     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        run_table();
        do_reset();
        run_backpressure();
        run_midflight_reset();
        do_reset();
        run_simultaneous();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            run_random(300);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ghpc_share_decoder.md
# ghpc_share_decoder

Receiving end of a masked GHPC d1 gadget pipeline. The block tracks values issued into a fixed-latency two-share pipeline and captures the arriving share pair at the correct cycle. It registers both shares, then recombines them to unmasked data. Results are buffered in a credit-protected FIFO with a valid/ready output handshake. It sits at the output of a gadget cascade, such as two chained d1 AND gadgets with LAT = 4, and is the only place where shares are recombined.

## Interface
Parameters:
- W, 1, data width per share
- LAT, 4, cycles from accepted issue to share pair valid at sh0/sh1 (≥1)
- DEPTH, 4, output FIFO entries (≥1, power of two)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- issue  in  1  upstream launches one value into the gadget pipeline this cycle
- issue_ok  out  1  credit available; issue accepted only when high
- sh0  in  W  share 0 from the gadget pipeline
- sh1  in  W  share 1 from the gadget pipeline
- out_data  out  W  unmasked result, head of FIFO
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when high with out_valid
- drop_err  out  1  sticky: issue asserted while issue_ok low

## Operation
- Accept: acc = issue & issue_ok. If issue is high while issue_ok is low, drop_err is set, the issue is not tracked, and occ is unchanged.
- Tag pipe: a LAT-bit shift register; bit 0 is loaded with acc each cycle. Bit LAT-1 marks the cycle in which sh0/sh1 carry a valid pair.
- Capture: when the tag is at stage LAT-1, sh0 and sh1 are loaded into separate registers s0_q, s1_q, and cap_v is set for one cycle. Shares are never combined before these registers (glitch isolation). sh0/sh1 are ignored in untagged cycles.
- Recombine: when cap_v is high, s0_q ^ s1_q is written to the FIFO tail. There is no combinational path from sh0/sh1 to the FIFO or outputs.
- FIFO: DEPTH entries, rd/wr pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
  - out_data = mem[rd]; pop = out_valid & out_ready.
  - No write-to-output bypass.
- Credit: occ, log2(DEPTH)+1 bits.
  - Next occ = occ + acc − pop.
  - issue_ok = (occ < DEPTH), decoded from registered occ only. A pop does not return credit in the same cycle.
  - occ bounds FIFO count plus in-flight tags, so a write to a full FIFO cannot occur. The write-while-full case needs no handling.
- Simultaneous FIFO write and pop: both take effect; count is unchanged.
- drop_err is cleared only by reset.

## Timing
- Reset values:
  - issue_ok = 1 (DEPTH ≥ 1); out_valid = 0; out_data = 0 (mem cleared); drop_err = 0.
  - Tag pipe, cap_v, s0_q, s1_q, occ, count and pointers are all 0.
- Latency for acc sampled at edge E0:
  - shares sampled at edge E0+LAT;
  - FIFO written at edge E0+LAT+1;
  - out_valid high from E0+LAT+1 if the FIFO was empty.
  - Issue to out_valid is LAT+1 cycles.
- Throughput: one issue per cycle while credit remains. Back-to-back issues produce back-to-back outputs in issue order.
- Credit stall: with out_ready = 0, issue_ok falls after DEPTH accepts. After a pop at edge P, issue_ok is high from edge P.
- Reset mid-operation: all tags are discarded. Shares from values already in the gadget pipeline are ignored because no tag exists for them. The FIFO is emptied and issue_ok is high on the first cycle after release.
- Reset deassertion must meet clk recovery/removal. The synchroniser is external.

## Test plan
- Reset: hold rst_n = 0 over 3 edges. Required: out_valid = 0, out_data = 0, issue_ok = 1, drop_err = 0.
- Single value, W = 1, LAT = 4: issue at edge 0; sh0 = 1, sh1 = 0 at edge 4. Required: out_valid = 1 and out_data = 1 from edge 5. With out_ready = 1, out_valid = 0 after edge 6.
- Recombination and masking:
  - Pairs (1,1), (0,1), (0,0) on consecutive issues yield 0, 1, 0 in order.
  - sh0/sh1 toggling in untagged cycles produce no FIFO write.
- Backpressure, DEPTH = 4, out_ready = 0: issue on 5 consecutive cycles. Required:
  - issue_ok = 0 after the 4th accept; the 5th sets drop_err = 1;
  - 4 entries appear in order;
  - one pop restores issue_ok = 1 on the following cycle.
- Simultaneous issue and pop at occ = 2 with a FIFO write in the same cycle: occ stays 2, count is unchanged, and data order is preserved.
- Reset mid-flight: issue 3 values, assert rst_n = 0 at edge 2, release, and drive valid-looking shares at edges 4–6. Required: no out_valid, issue_ok = 1, drop_err = 0.
